soc_result_mailbox: RTL and testbench
=====================================

# soc_result_mailbox

Memory-mapped responder shared by the two cores of the multi-core dual-port-RAM SoC. Each core's data bus reaches it through its own request/grant/rvalid port. It arbitrates the two ports and holds the test-status registers the SoC exports as `mem_flag` and `mem_result`. It also provides a cycle counter and per-core done bits, which give the bench a clean end-of-test indication.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100: watchdog limit in clock cycles. Used only when `MAILBOX_TIMEOUT_EN` is defined.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous active-high reset
- `data_req_i[1:0]`  in  2  request, one bit per port (index 0 = core 1, index 1 = core 2)
- `data_we_i[1:0]`  in  2  write enable per port
- `data_be_i[p]`  in  4  byte enables per port
- `data_addr_i[p]`  in  32  byte address per port; only bits [3:2] decoded
- `data_wdata_i[p]`  in  32  write data per port
- `data_gnt_o[1:0]`  out  2  grant per port
- `data_rvalid_o[1:0]`  out  2  response valid per port
- `data_rdata_o[p]`  out  32  read data per port
- `mem_flag`  out  32  FLAG register
- `mem_result`  out  32  RESULT register
- `all_done_o`  out  1  both done bits set
- `timeout_o`  out  1  sticky watchdog flag

## Operation
- Register map, selected by addr[3:2]:
  - 0x0 FLAG: read/write, byte enables honoured.
  - 0x4 RESULT: read/write, byte enables honoured.
  - 0x8 CYCLES: read-only; writes are acknowledged and ignored.
  - 0xC DONE: a write with wdata[0]=1 and be[0]=1 sets `done[p]` for the writing port. Writing 0 has no effect; done bits clear only on reset. Read value is {timeout, 29'b0, done[1], done[0]}.
- Arbitration:
  - At most one grant per cycle.
  - A single requester is granted in the same cycle.
  - When both ports request, the round-robin pointer picks the winner. After a contested grant the pointer moves to the other port; uncontested grants leave it unchanged.
  - Pointer reset value is port 0.
  - The loser keeps `req` high and is granted in a later cycle.
- `gnt` is combinational from `req` and the pointer. The requester must hold addr/we/be/wdata stable until granted.
- Writes commit on the clock edge that ends the grant cycle.
- CYCLES counter:
  - 32-bit, cleared by reset, increments every cycle.
  - Wraps 0xFFFFFFFF -> 0.
  - Freezes once `all_done_o` is 1.
- `all_done_o` = done[0] & done[1], registered.

## Timing
- Reset values: `mem_flag`=0, `mem_result`=0, CYCLES=0, done=0, `timeout_o`=0, `data_gnt_o`=0, `data_rvalid_o`=0, `data_rdata_o`=0, `all_done_o`=0.
- Response latency:
  - `data_rvalid_o[p]` is high for exactly one cycle, the cycle after `data_gnt_o[p]`. This holds for both reads and writes.
  - `data_rdata_o[p]` is valid only while rvalid is high and is 0 for writes.
- A written value appears on `mem_flag`/`mem_result` one cycle after the grant.
- Read data reflects register state at the grant edge. A read granted in the cycle after a write by the other port returns the new value.
- Back-to-back requests from the same uncontested port are granted every cycle, overlapping with the previous rvalid.
- CYCLES read data is the counter value at the grant edge.
- Reset asserted mid-transaction: pending rvalid is dropped, no response is issued, and the pointer returns to port 0.

## Configuration
- `MAILBOX_TIMEOUT_EN` defined:
  - When CYCLES reaches `TIMEOUT_CYCLES` while `all_done_o`=0, `timeout_o` goes high the next cycle and stays high until reset.
  - `timeout_o` is also visible in DONE[31].
  - If `all_done_o` is already set, timeout never fires.
- `MAILBOX_TIMEOUT_EN` undefined: `timeout_o` is tied 0, DONE[31] reads 0, and the parameter is ignored.

## Test plan
- Reset, then port 0 writes 0x4 = 0x0000002A with be=0xF -> gnt in the same cycle, rvalid[0] one cycle later, `mem_result`=42 one cycle after gnt, no rvalid on port 1.
- Both ports write FLAG in the same cycle (port 0 = 0x1, port 1 = 0x2) -> port 0 is granted first, port 1 the next cycle, final `mem_flag`=0x2. A second simultaneous pair is granted port 1 first.
- Port 1 writes FLAG with be=0b0010 and wdata=0xAABBCCDD over 0 -> `mem_flag`=0x0000CC00.
- Both cores write 1 to DONE, port 0 at cycle 20 and port 1 at cycle 30 -> `all_done_o` rises after the second write. A later CYCLES read returns a constant value on two reads 10 cycles apart.
- With `MAILBOX_TIMEOUT_EN` and TIMEOUT_CYCLES=100, no DONE writes -> `timeout_o`=1 at cycle 101 and sticky, DONE read returns 0x80000000. Without the macro, `timeout_o` stays 0.
- Reset asserted in the cycle after a granted read -> no rvalid, all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/soc_result_mailbox.sv
// Two-port result mailbox (FLAG/RESULT/CYCLES/DONE) behind a round-robin arbiter; `MAILBOX_TIMEOUT_EN enables the watchdog.
// Grant is combinational in the request cycle; rvalid/rdata follow one cycle later. A losing port holds req until granted.
module soc_result_mailbox #(
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       data_req_i,
   input  logic [1:0]       data_we_i,
   input  logic [1:0][3:0]  data_be_i,
   input  logic [1:0][31:0] data_addr_i,
   input  logic [1:0][31:0] data_wdata_i,
   output logic [1:0]       data_gnt_o,
   output logic [1:0]       data_rvalid_o,
   output logic [1:0][31:0] data_rdata_o,
   output logic [31:0]      mem_flag,
   output logic [31:0]      mem_result,
   output logic             all_done_o,
   output logic             timeout_o
);

   logic             ptr_q, ptr_d;
   logic [1:0]       gnt;
   logic             sel;
   logic             sel_we;
   logic [3:0]       sel_be;
   logic [1:0]       sel_reg;
   logic [31:0]      sel_wdata;
   logic [31:0]      rd_val;
   logic [31:0]      flag_q, flag_d;
   logic [31:0]      result_q, result_d;
   logic [31:0]      cycles_q, cycles_d;
   logic [1:0]       done_q, done_d;
   logic             all_done_q, all_done_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       rvalid_q;
   logic [1:0][31:0] rdata_q, rdata_d;
   logic             unused_addr;

   function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   // Grants are forced low while reset is held so nothing is acknowledged that cannot complete.
   always_comb begin
      gnt = 2'b00;
      if (!rst_i) begin
         if (data_req_i == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
         else                     gnt = data_req_i;
      end
   end

   assign sel       = gnt[1];
   assign sel_we    = data_we_i[sel];
   assign sel_be    = data_be_i[sel];
   assign sel_reg   = data_addr_i[sel][3:2];
   assign sel_wdata = data_wdata_i[sel];

   always_comb begin
      case (sel_reg)
         2'd0:    rd_val = flag_q;
         2'd1:    rd_val = result_q;
         2'd2:    rd_val = cycles_q;
         default: rd_val = {timeout_q, 29'd0, done_q};
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      flag_d     = flag_q;
      result_d   = result_q;
      done_d     = done_q;
      rdata_d    = '0;
      cycles_d   = all_done_q ? cycles_q : cycles_q + 32'd1;
      all_done_d = &done_q;
`ifdef MAILBOX_TIMEOUT_EN
      timeout_d  = timeout_q | ((cycles_q == TIMEOUT_CYCLES) && !all_done_q);
`else
      timeout_d  = 1'b0;
`endif
      if (|gnt) begin
         if (data_req_i == 2'b11) ptr_d = ~sel;
         if (sel_we) begin
            case (sel_reg)
               2'd0: flag_d   = merge_be(flag_q, sel_wdata, sel_be);
               2'd1: result_d = merge_be(result_q, sel_wdata, sel_be);
               2'd3: if (sel_be[0] && sel_wdata[0]) done_d[sel] = 1'b1;
               default: ;
            endcase
         end else begin
            rdata_d[sel] = rd_val;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q      <= 1'b0;
         flag_q     <= '0;
         result_q   <= '0;
         cycles_q   <= '0;
         done_q     <= '0;
         all_done_q <= 1'b0;
         timeout_q  <= 1'b0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         flag_q     <= flag_d;
         result_q   <= result_d;
         cycles_q   <= cycles_d;
         done_q     <= done_d;
         all_done_q <= all_done_d;
         timeout_q  <= timeout_d;
         rvalid_q   <= gnt;
         rdata_q    <= rdata_d;
      end
   end

`ifndef MAILBOX_TIMEOUT_EN
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif
   assign unused_addr = ^{data_addr_i[0][31:4], data_addr_i[0][1:0],
                          data_addr_i[1][31:4], data_addr_i[1][1:0]};

   assign data_gnt_o    = gnt;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;
   assign mem_flag      = flag_q;
   assign mem_result    = result_q;
   assign all_done_o    = all_done_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_soc_result_mailbox.sv
// Bench for soc_result_mailbox: a transaction-level model predicts grants, register contents and
// responses; a negedge monitor pops expected responses and compares every cycle.
`timescale 1ns/1ps
module tb_soc_result_mailbox;

   localparam int TO = 100;
`ifdef MAILBOX_TIMEOUT_EN
   localparam logic        EXP_TO   = 1'b1;
   localparam logic [31:0] EXP_DONE = 32'h8000_0000;
`else
   localparam logic        EXP_TO   = 1'b0;
   localparam logic [31:0] EXP_DONE = 32'h0000_0000;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0]       req = '0, we = '0;
   logic [1:0][3:0]  be = '0;
   logic [1:0][31:0] addr = '0, wdata = '0;
   logic [1:0]       gnt, rvalid;
   logic [1:0][31:0] rdata;
   logic [31:0]      flag, result;
   logic             all_done, timeout;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   soc_result_mailbox #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(req), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata),
      .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
      .mem_flag(flag), .mem_result(result),
      .all_done_o(all_done), .timeout_o(timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errs++;
      $display("FAIL %s: got no completion, expected one within bound (t=%0t)", nm, $time);
   endtask

   function automatic int winner(input logic [1:0] r, input int ptr);
      if (r == 2'b11) return ptr;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
   endfunction

   function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // Reference model: one transaction per edge, responses queued per port.
   logic [31:0] m_flag = '0, m_result = '0, m_cyc = '0;
   logic [1:0]  m_done = '0;
   logic        m_all = 1'b0, m_to = 1'b0;
   int          m_ptr = 0;
   logic [1:0]  last_win = '0;
   logic [31:0] expq0[$];
   logic [31:0] expq1[$];
   int          w;
   logic [31:0] rv, ocyc;
   logic [1:0]  odone;
   logic        oall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_flag = '0; m_result = '0; m_cyc = '0; m_done = '0;
         m_all = 1'b0; m_to = 1'b0; m_ptr = 0; last_win = '0;
         expq0.delete(); expq1.delete();
      end else begin
         ocyc = m_cyc; odone = m_done; oall = m_all;
         w = winner(req, m_ptr);
         last_win = '0;
         if (w >= 0) begin
            last_win[w] = 1'b1;
            case (addr[w][3:2])
               2'd0:    rv = m_flag;
               2'd1:    rv = m_result;
               2'd2:    rv = m_cyc;
               default: rv = {m_to, 29'd0, m_done};
            endcase
            if (req == 2'b11) m_ptr = 1 - w;
            if (we[w]) begin
               rv = '0;
               case (addr[w][3:2])
                  2'd0: m_flag   = apply_be(m_flag, wdata[w], be[w]);
                  2'd1: m_result = apply_be(m_result, wdata[w], be[w]);
                  2'd3: if (be[w][0] && wdata[w][0]) m_done[w] = 1'b1;
                  default: ;
               endcase
            end
            if (w == 0) expq0.push_back(rv);
            else        expq1.push_back(rv);
         end
         m_all = &odone;
         m_cyc = oall ? ocyc : ocyc + 32'd1;
`ifdef MAILBOX_TIMEOUT_EN
         if (ocyc == TO && !oall) m_to = 1'b1;
`endif
      end
   end

   // Monitor
   int          mw;
   logic [1:0]  eg;
   logic        ev;
   logic [31:0] ed;
   always @(negedge clk) begin
      if (!rst) begin
         mw = winner(req, m_ptr);
         eg = 2'b00;
         if (mw >= 0) eg[mw] = 1'b1;
         chk("gnt", 32'(gnt), 32'(eg));
         chk("mem_flag", flag, m_flag);
         chk("mem_result", result, m_result);
         chk("all_done", 32'(all_done), 32'(m_all));
         chk("timeout", 32'(timeout), 32'(m_to));
         ev = (expq0.size() != 0);
         chk("rvalid0", 32'(rvalid[0]), 32'(ev));
         if (ev) begin
            ed = expq0.pop_front();
            if (rvalid[0]) chk("rdata0", rdata[0], ed);
         end
         ev = (expq1.size() != 0);
         chk("rvalid1", 32'(rvalid[1]), 32'(ev));
         if (ev) begin
            ed = expq1.pop_front();
            if (rvalid[1]) chk("rdata1", rdata[1], ed);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic issue(input int p, input logic wr, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      req[p] = 1'b1; we[p] = wr; addr[p] = a; be[p] = b; wdata[p] = d;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (last_win[p]) begin
            req[p] = 1'b0;
            return;
         end
      end
      req[p] = 1'b0;
      fail_now($sformatf("grant_p%0d", p));
   endtask

   task automatic pair(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1, output int first);
      req = 2'b11; we = 2'b11; be[0] = 4'hF; be[1] = 4'hF;
      addr[0] = a; addr[1] = a; wdata[0] = d0; wdata[1] = d1;
      first = -1;
      for (int n = 0; n < 10 && req != 2'b00; n++) begin
         @(posedge clk); #1;
         if (first < 0) first = last_win[0] ? 0 : (last_win[1] ? 1 : -1);
         req = req & ~last_win;
      end
      if (req != 2'b00) begin
         fail_now("pair_grant");
         req = 2'b00;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 10 && req != 2'b00; n++) begin
         @(posedge clk); #1;
         req = req & ~last_win;
      end
      if (req != 2'b00) begin
         fail_now("drain");
         req = 2'b00;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200us");
      $fatal(1);
   end

   initial begin
      int f;
      logic [31:0] r0, r1;
      #1 rst = 1'b1;
      #2;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata0", rdata[0], 32'h0);
      chk("rst_rdata1", rdata[1], 32'h0);
      chk("rst_flag", flag, 32'h0);
      chk("rst_result", result, 32'h0);
      chk("rst_all_done", 32'(all_done), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      issue(0, 1'b1, 32'h4, 4'hF, 32'h2A);
      chk("wr_result_rvalid", 32'(rvalid), 32'h1);
      chk("wr_result_val", result, 32'd42);

      pair(32'h0, 32'h1, 32'h2, f);
      chk("pair1_first", 32'(f), 32'h0);
      chk("pair1_flag", flag, 32'h2);
      pair(32'h0, 32'h3, 32'h4, f);
      chk("pair2_first", 32'(f), 32'h1);
      chk("pair2_flag", flag, 32'h3);

      issue(0, 1'b1, 32'h0, 4'hF, 32'h0);
      issue(1, 1'b1, 32'h0, 4'b0010, 32'hAABBCCDD);
      chk("be_flag", flag, 32'h0000CC00);

      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (!req[p] || last_win[p]) begin
               if ($urandom_range(0, 99) < 60) begin
                  req[p] = 1'b1;
                  we[p] = 1'($urandom_range(0, 1));
                  be[p] = 4'($urandom_range(0, 15));
                  addr[p] = $urandom;
                  wdata[p] = $urandom;
                  if (addr[p][3:2] == 2'd3 && we[p]) wdata[p][0] = 1'b0;
               end else begin
                  req[p] = 1'b0;
               end
            end
         end
      end
      drain();
      chk("timeout_sticky", 32'(timeout), 32'(EXP_TO));
      issue(0, 1'b0, 32'hC, 4'hF, 32'h0);
      chk("done_read", rdata[0], EXP_DONE);

      for (int k = 0; k < 2 && m_ptr != 1; k++) pair(32'h4, $urandom, $urandom, f);

      issue(0, 1'b1, 32'hC, 4'hF, 32'h1);
      idle(9);
      chk("done_one_only", 32'(all_done), 32'h0);
      issue(1, 1'b1, 32'hC, 4'hF, 32'h1);
      chk("all_done_lag", 32'(all_done), 32'h0);
      idle(1);
      chk("all_done_set", 32'(all_done), 32'h1);
      issue(0, 1'b0, 32'h8, 4'hF, 32'h0);
      r0 = m_cyc;
      chk("cycles_frozen_a", rdata[0], r0);
      idle(10);
      issue(1, 1'b0, 32'h8, 4'hF, 32'h0);
      r1 = r0;
      chk("cycles_frozen_b", rdata[1], r1);

      issue(0, 1'b0, 32'h8, 4'hF, 32'h0);
      chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
      chk("mid_rst_rdata0", rdata[0], 32'h0);
      chk("mid_rst_flag", flag, 32'h0);
      chk("mid_rst_result", result, 32'h0);
      chk("mid_rst_all_done", 32'(all_done), 32'h0);
      chk("mid_rst_timeout", 32'(timeout), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      pair(32'h4, 32'h11, 32'h22, f);
      chk("post_rst_first", 32'(f), 32'h0);
      chk("post_rst_result", result, 32'h22);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
